// File: rtl/spi_reg_slave_if.sv
// SPI pin bundle between an initiator (master modport) and spi_reg_slave (slave modport).
interface spi_reg_slave_if;
  logic       spi_sclk;
  logic       spi_cs;
  logic       spi_sdi0;
  logic       spi_sdi1;
  logic       spi_sdi2;
  logic       spi_sdi3;
  logic       spi_sdo0;
  logic       spi_sdo1;
  logic       spi_sdo2;
  logic       spi_sdo3;
  logic [1:0] spi_mode;

  modport master (
    output spi_sclk, spi_cs, spi_sdi0, spi_sdi1, spi_sdi2, spi_sdi3,
    input  spi_sdo0, spi_sdo1, spi_sdo2, spi_sdo3, spi_mode
  );

  modport slave (
    input  spi_sclk, spi_cs, spi_sdi0, spi_sdi1, spi_sdi2, spi_sdi3,
    output spi_sdo0, spi_sdo1, spi_sdo2, spi_sdo3, spi_mode
  );
endinterface

// File: rtl/spi_reg_slave.sv
// SPI mode-0 register responder: 8-bit opcode, then a 32-bit read or write of reg0/reg1.
// Quad-output reads (opcodes 0x0D/0x0F) are built only when SPI_QUAD_EN is defined.
module spi_reg_slave #(
  parameter logic [31:0] REG0_RST     = 32'h0000_0000,
  parameter logic [31:0] REG1_RST     = 32'd32,
  parameter int unsigned DUMMY_CYCLES = 0
) (
  input  logic           clk_i,
  input  logic           rst_i,
  spi_reg_slave_if.slave spi,
  output logic [31:0]    reg0_o,
  output logic [31:0]    reg1_o,
  output logic           reg_we_o,
  output logic           reg_idx_o
);

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    DUMMY,
    RD_DATA,
    WR_DATA,
    COMMIT,
    DISCARD
  } state_t;

  localparam logic [5:0] DUMMY_LAST = (DUMMY_CYCLES > 0) ? 6'(DUMMY_CYCLES - 1) : 6'd0;

  state_t      state;
  state_t      next_state;

  logic [2:0]  sclk_sync;
  logic [2:0]  cs_sync;
  logic [2:0]  sdi_sync;
  logic        sclk_rise;
  logic        sclk_fall;
  logic        cs_s;
  logic        sdi_s;
  logic        armed;

  logic [5:0]  bit_cnt;
  logic [6:0]  cmd_shift;
  logic [30:0] wr_shift;
  logic [31:0] rd_shift;
  logic [3:0]  sdo_q;
  logic        idx_q;
  logic        quad_q;

  logic [7:0]  cmd_word;
  logic        dec_wr;
  logic        dec_rd;
  logic        dec_quad;
  logic        dec_idx;
  logic        last_wr_bit;
  logic        rd_sel;
  logic [5:0]  rd_last;

  // Two-flop synchronizers plus a history flop; armed blocks a new transaction after
  // reset until chip select has been seen high.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sclk_sync <= '0;
      cs_sync   <= '0;
      sdi_sync  <= '0;
      armed     <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[1:0], spi.spi_sclk};
      cs_sync   <= {cs_sync[1:0], spi.spi_cs};
      sdi_sync  <= {sdi_sync[1:0], spi.spi_sdi0};
      if (cs_sync[2]) begin
        armed <= 1'b1;
      end
    end
  end

  assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
  assign sclk_fall = ~sclk_sync[1] & sclk_sync[2];
  assign cs_s      = cs_sync[1];
  assign sdi_s     = sdi_sync[2];

  assign cmd_word    = {cmd_shift, sdi_s};
  assign last_wr_bit = (state == WR_DATA) && sclk_rise && (bit_cnt == 6'd31);
  assign rd_sel      = (state == CMD) ? dec_idx : idx_q;
  assign rd_last     = quad_q ? 6'd7 : 6'd31;

  always_comb begin
    dec_wr   = 1'b0;
    dec_rd   = 1'b0;
    dec_quad = 1'b0;
    dec_idx  = 1'b0;
    case (cmd_word)
      8'h01: dec_wr = 1'b1;
      8'h11: begin
        dec_wr  = 1'b1;
        dec_idx = 1'b1;
      end
      8'h05: dec_rd = 1'b1;
      8'h07: begin
        dec_rd  = 1'b1;
        dec_idx = 1'b1;
      end
`ifdef SPI_QUAD_EN
      8'h0D: begin
        dec_rd   = 1'b1;
        dec_quad = 1'b1;
      end
      8'h0F: begin
        dec_rd   = 1'b1;
        dec_quad = 1'b1;
        dec_idx  = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Chip select high wins everywhere except on the final write edge, which is seen first.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (armed && !cs_s) begin
          next_state = CMD;
        end
      end
      CMD: begin
        if (sclk_rise && bit_cnt == 6'd7) begin
          if (dec_wr) begin
            next_state = WR_DATA;
          end else if (dec_rd) begin
            next_state = (DUMMY_CYCLES > 0) ? DUMMY : RD_DATA;
          end else begin
            next_state = DISCARD;
          end
        end
      end
      DUMMY: begin
        if (sclk_rise && bit_cnt == DUMMY_LAST) begin
          next_state = RD_DATA;
        end
      end
      RD_DATA: begin
        if (sclk_rise && bit_cnt == rd_last) begin
          next_state = DISCARD;
        end
      end
      WR_DATA: begin
        if (last_wr_bit) begin
          next_state = COMMIT;
        end
      end
      COMMIT:  next_state = DISCARD;
      DISCARD: next_state = DISCARD;
      default: next_state = IDLE;
    endcase
    if (cs_s && !last_wr_bit) begin
      next_state = IDLE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bit_cnt   <= '0;
      cmd_shift <= '0;
      wr_shift  <= '0;
      rd_shift  <= '0;
      sdo_q     <= '0;
      idx_q     <= 1'b0;
      quad_q    <= 1'b0;
      reg0_o    <= REG0_RST;
      reg1_o    <= REG1_RST;
      reg_we_o  <= 1'b0;
      reg_idx_o <= 1'b0;
    end else begin
      reg_we_o <= 1'b0;
      if (next_state == IDLE) begin
        bit_cnt   <= '0;
        cmd_shift <= '0;
        wr_shift  <= '0;
        rd_shift  <= '0;
        sdo_q     <= '0;
        quad_q    <= 1'b0;
      end else begin
        if (next_state != state) begin
          bit_cnt <= '0;
        end else if (sclk_rise && bit_cnt != 6'h3F) begin
          bit_cnt <= bit_cnt + 6'd1;
        end

        if (state == CMD && sclk_rise) begin
          cmd_shift <= cmd_word[6:0];
          if (bit_cnt == 6'd7) begin
            idx_q  <= dec_idx;
            quad_q <= dec_quad;
          end
        end

        if (state == WR_DATA && sclk_rise) begin
          wr_shift <= {wr_shift[29:0], sdi_s};
        end

        // The first bit is driven on the falling edge after the read data is latched.
        if (next_state == RD_DATA && state != RD_DATA) begin
          rd_shift <= rd_sel ? reg1_o : reg0_o;
        end else if (state == RD_DATA && sclk_fall) begin
          if (quad_q) begin
            sdo_q    <= rd_shift[31:28];
            rd_shift <= {rd_shift[27:0], 4'h0};
          end else begin
            sdo_q    <= {3'b000, rd_shift[31]};
            rd_shift <= {rd_shift[30:0], 1'b0};
          end
        end

        if (state != RD_DATA) begin
          sdo_q <= '0;
        end

        if (next_state == COMMIT) begin
          reg_we_o  <= 1'b1;
          reg_idx_o <= idx_q;
          if (idx_q) begin
            reg1_o <= {wr_shift, sdi_s};
          end else begin
            reg0_o <= {wr_shift, sdi_s};
          end
        end
      end
    end
  end

  assign spi.spi_sdo0 = sdo_q[0];

`ifdef SPI_QUAD_EN
  assign spi.spi_sdo1 = sdo_q[1];
  assign spi.spi_sdo2 = sdo_q[2];
  assign spi.spi_sdo3 = sdo_q[3];
  assign spi.spi_mode = (state == RD_DATA && quad_q) ? 2'b10 : 2'b00;
`else
  logic unused_quad;
  assign unused_quad  = ^sdo_q[3:1];
  assign spi.spi_sdo1 = 1'b0;
  assign spi.spi_sdo2 = 1'b0;
  assign spi.spi_sdo3 = 1'b0;
  assign spi.spi_mode = 2'b00;
`endif

  logic unused_sdi;
  assign unused_sdi = ^{spi.spi_sdi1, spi.spi_sdi2, spi.spi_sdi3};

endmodule
